vec_calc_seq: RTL and testbench
===============================

# vec_calc_seq

Sequencer for the accelerator's element-wise vector engine. It owns the single-port 8K x 32 scratch SRAM, which it shares with the ICB register slave's host read/write path. For each element it reads operand A, reads operand B, computes a 32-bit result and writes it back. The host path always has priority, so the sequencer stalls whenever the host touches the SRAM. Configuration comes from the slave's CONFIG/CALCBASE/RWBASE registers; status feeds back into STAT_REG_RD.

## Interface
Parameters:
- AW, 13, SRAM word-address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle pulse; begins a job when in IDLE.
- abort  in  1  one-cycle pulse; cancels the current job.
- done_clr  in  1  clears sticky `done`.
- cfg_len  in  AW  number of elements N, 0..8191.
- cfg_op  in  2  operation: 0 add, 1 sub (A-B), 2 xor, 3 unsigned max.
- src_a_base / src_b_base / dst_base  in  AW each  word base addresses.
- host_wr_en  in  1  host write request.
- host_wr_addr  in  AW  host write address.
- host_wr_data  in  DW  host write data.
- host_rd_en  in  1  host read request.
- host_rd_addr  in  AW  host read address.
- host_rd_data  out  DW  combinational pass-through of sram_rdata.
- sram_en  out  1  SRAM access strobe.
- sram_we  out  1  SRAM write strobe.
- sram_addr  out  AW  SRAM address.
- sram_wdata  out  DW  SRAM write data.
- sram_rdata  in  DW  SRAM read data, valid the cycle after a read strobe.
- busy  out  1  job in progress.
- done  out  1  sticky job-complete flag.
- elem_cnt  out  AW  elements written in the current or last job.

## Operation
- States: IDLE, RD_A, RD_B, CALC, WR, DONE.
- IDLE:
  - `start` with `abort` low latches cfg_len, cfg_op and the three bases, clears idx, elem_cnt and done.
  - It then goes to RD_A, or to DONE if cfg_len == 0.
  - `start` outside IDLE is ignored.
- Port arbitration (combinational), in priority order:
  - host_wr_en: write.
  - else host_rd_en: read.
  - else the engine request.
  - Engine grant = engine request AND NOT host_wr_en AND NOT host_rd_en.
  - host_wr_en and host_rd_en together: write wins; the read is dropped.
  - With no request active: sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0.
- RD_A:
  - Requests a read at src_a_base+idx.
  - On grant, sets a_pend and moves to RD_B; otherwise holds.
- RD_B:
  - Requests a read at src_b_base+idx.
  - On grant, sets b_pend and moves to CALC.
- Operand capture:
  - In any cycle where a_pend is set, sram_rdata is captured into opA and a_pend clears.
  - The same applies to b_pend and opB.
- CALC:
  - No port request.
  - The result register loads f(opA, opB) using the latched op.
  - Moves to WR.
- WR:
  - Requests a write of the result to dst_base+idx.
  - On grant, idx and elem_cnt increment.
  - If idx == N-1, moves to DONE; else moves to RD_A.
- DONE: one cycle, sets done, then moves to IDLE.
- Arithmetic:
  - Add and sub wrap modulo 2^32, no flags.
  - Max is an unsigned compare.
  - Addresses are base+idx modulo 2^AW (wrap from 8191 to 0).
- abort:
  - In any non-IDLE state: next state IDLE, pending flags cleared, done not set.
  - elem_cnt holds its partial count.
  - A write being requested in the same cycle is still issued if granted.
  - In IDLE, abort wins over start.
- busy = (state != IDLE).
- done clears on done_clr or on an accepted start; set has priority over clear in the same cycle.

## Timing
- Reset values: state IDLE, busy 0, done 0, elem_cnt 0, opA/opB/result 0, pending flags 0.
  - sram_* then reflect only host requests.
  - host_rd_data always equals sram_rdata.
- Cycle 0: start sampled. Cycle 1: RD_A.
- Without host contention:
  - Element i occupies cycles 4i+1 (RD_A), 4i+2 (RD_B), 4i+3 (CALC), 4i+4 (WR).
  - DONE is at cycle 4N+1.
  - busy=0 and done=1 from cycle 4N+2.
- Each cycle a host access collides with RD_A, RD_B or WR adds exactly one stall cycle.
- Host collisions during CALC, DONE or IDLE cost nothing.
- N=0: DONE at cycle 1; done=1, busy=0 at cycle 2; no SRAM access.
- Host read data appears on host_rd_data the cycle after host_rd_en, unaffected by engine activity.

## Test plan
- Add, no contention:
  - Stimulus: N=4, A=[1,2,3,0xFFFFFFFF] @0x100, B=[10,20,30,2] @0x200, dst 0x300.
  - Required: mem[0x300..0x303]=[11,22,33,1]; done rises at cycle 18; elem_cnt=4.
- Host stall:
  - Stimulus: same job, host writes asserted on cycles 1, 2 and 8 (RD_A, RD_B, WR).
  - Required: host data lands; results unchanged; done is 3 cycles late (cycle 21).
- Sub and max with address wrap:
  - Stimulus: op=1, N=2, src_a_base=8191, A=[5,0], B=[7,1].
  - Required: results [0xFFFFFFFE, 0xFFFFFFFF]; A is read from 8191 then 0.
  - Repeat with op=3: results [7,1].
- N=0: start -> no sram_en, done=1 and busy=0 at cycle 2.
- Abort mid-job:
  - Stimulus: N=8, abort at cycle 10.
  - Required: IDLE at cycle 11; done=0; elem_cnt=2; dst words 2..7 untouched.
  - A start issued while busy is ignored; done_clr then start restarts the job cleanly.
- Reset mid-job: rst during element 3 -> next cycle all outputs at reset values; a fresh start runs normally.

Source files
------------

// File: rtl/vec_calc_seq.sv
// vec_calc_seq: element-wise vector sequencer (read A, read B, compute, write)
// sharing a single-port scratch SRAM with the host path; host accesses always win.
module vec_calc_seq #(
  parameter int AW = 13,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          done_clr,
  input  logic [AW-1:0] cfg_len,
  input  logic [1:0]    cfg_op,
  input  logic [AW-1:0] src_a_base,
  input  logic [AW-1:0] src_b_base,
  input  logic [AW-1:0] dst_base,
  input  logic          host_wr_en,
  input  logic [AW-1:0] host_wr_addr,
  input  logic [DW-1:0] host_wr_data,
  input  logic          host_rd_en,
  input  logic [AW-1:0] host_rd_addr,
  output logic [DW-1:0] host_rd_data,
  output logic          sram_en,
  output logic          sram_we,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wdata,
  input  logic [DW-1:0] sram_rdata,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] elem_cnt
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] RD_A = 3'd1;
  localparam logic [2:0] RD_B = 3'd2;
  localparam logic [2:0] CALC = 3'd3;
  localparam logic [2:0] WR   = 3'd4;
  localparam logic [2:0] DONE = 3'd5;
  localparam logic [AW-1:0] ONE = AW'(1);

  logic [2:0]    state_r, state_nxt_s;
  logic [AW-1:0] len_r, a_base_r, b_base_r, d_base_r, idx_r, elem_cnt_r;
  logic [1:0]    op_r;
  logic          done_r, a_pend_r, b_pend_r;
  logic [DW-1:0] op_a_r, op_b_r, result_r, op_a_s, op_b_s;
  logic          eng_req_s, eng_we_s, grant_s, accept_s;
  logic [AW-1:0] eng_addr_s;

  function automatic logic [DW-1:0] calc_op(input logic [1:0] op,
                                            input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    case (op)
      2'd0:    calc_op = a + b;
      2'd1:    calc_op = a - b;
      2'd2:    calc_op = a ^ b;
      2'd3:    calc_op = (a > b) ? a : b;
      default: calc_op = '0;
    endcase
  endfunction

  assign host_rd_data = sram_rdata;
  assign busy         = (state_r != IDLE);
  assign done         = done_r;
  assign elem_cnt     = elem_cnt_r;
  assign grant_s      = eng_req_s & ~host_wr_en & ~host_rd_en;
  assign accept_s     = (state_r == IDLE) & start & ~abort;
  // B read data is still on the bus during CALC, so forward it into the ALU
  assign op_a_s       = a_pend_r ? sram_rdata : op_a_r;
  assign op_b_s       = b_pend_r ? sram_rdata : op_b_r;

  // Engine port request derived from the current state
  always_comb begin
    eng_req_s  = 1'b0;
    eng_we_s   = 1'b0;
    eng_addr_s = '0;
    case (state_r)
      RD_A: begin
        eng_req_s  = 1'b1;
        eng_addr_s = a_base_r + idx_r;
      end
      RD_B: begin
        eng_req_s  = 1'b1;
        eng_addr_s = b_base_r + idx_r;
      end
      WR: begin
        eng_req_s  = 1'b1;
        eng_we_s   = 1'b1;
        eng_addr_s = d_base_r + idx_r;
      end
      default: begin
        eng_req_s  = 1'b0;
        eng_we_s   = 1'b0;
        eng_addr_s = '0;
      end
    endcase
  end

  // SRAM port mux: host write, then host read, then engine
  always_comb begin
    sram_en    = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (host_wr_en) begin
      sram_en    = 1'b1;
      sram_we    = 1'b1;
      sram_addr  = host_wr_addr;
      sram_wdata = host_wr_data;
    end else if (host_rd_en) begin
      sram_en    = 1'b1;
      sram_addr  = host_rd_addr;
    end else if (eng_req_s) begin
      sram_en    = 1'b1;
      sram_we    = eng_we_s;
      sram_addr  = eng_addr_s;
      sram_wdata = eng_we_s ? result_r : '0;
    end else begin
      sram_en    = 1'b0;
    end
  end

  // Next-state logic; abort returns to IDLE from anywhere
  always_comb begin
    state_nxt_s = state_r;
    if (abort) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_nxt_s = start ? ((cfg_len == '0) ? DONE : RD_A) : IDLE;
        RD_A:    state_nxt_s = grant_s ? RD_B : RD_A;
        RD_B:    state_nxt_s = grant_s ? CALC : RD_B;
        CALC:    state_nxt_s = WR;
        WR:      state_nxt_s = grant_s ? ((idx_r == len_r - ONE) ? DONE : RD_A) : WR;
        DONE:    state_nxt_s = IDLE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // Job state, datapath registers and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      len_r      <= '0;
      op_r       <= 2'd0;
      a_base_r   <= '0;
      b_base_r   <= '0;
      d_base_r   <= '0;
      idx_r      <= '0;
      elem_cnt_r <= '0;
      done_r     <= 1'b0;
      a_pend_r   <= 1'b0;
      b_pend_r   <= 1'b0;
      op_a_r     <= '0;
      op_b_r     <= '0;
      result_r   <= '0;
    end else begin
      state_r  <= state_nxt_s;
      a_pend_r <= (state_r == RD_A) & grant_s & ~abort;
      b_pend_r <= (state_r == RD_B) & grant_s & ~abort;
      if (a_pend_r) op_a_r <= sram_rdata;
      if (b_pend_r) op_b_r <= sram_rdata;
      if (state_r == CALC) result_r <= calc_op(op_r, op_a_s, op_b_s);
      if (accept_s) begin
        len_r      <= cfg_len;
        op_r       <= cfg_op;
        a_base_r   <= src_a_base;
        b_base_r   <= src_b_base;
        d_base_r   <= dst_base;
        idx_r      <= '0;
        elem_cnt_r <= '0;
      end else if ((state_r == WR) && grant_s) begin
        // a granted write still lands under abort, so it is counted
        idx_r      <= idx_r + ONE;
        elem_cnt_r <= elem_cnt_r + ONE;
      end
      if ((state_r == DONE) && !abort) begin
        done_r <= 1'b1;
      end else if (done_clr || accept_s) begin
        done_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vec_calc_seq.sv
// Bench for vec_calc_seq: SRAM model, access-order scoreboard and directed jobs.
module tb_vec_calc_seq;

  logic        clk = 1'b0;
  logic        rst, start, abort, done_clr;
  logic [12:0] cfg_len, src_a_base, src_b_base, dst_base;
  logic [1:0]  cfg_op;
  logic        host_wr_en, host_rd_en;
  logic [12:0] host_wr_addr, host_rd_addr;
  logic [31:0] host_wr_data, host_rd_data;
  logic        sram_en, sram_we;
  logic [12:0] sram_addr;
  logic [31:0] sram_wdata, sram_rdata;
  logic        busy, done;
  logic [12:0] elem_cnt;

  int n_vec = 0;
  int n_err = 0;
  logic mon_on = 1'b0;

  typedef struct packed {
    logic        we;
    logic [12:0] addr;
    logic [31:0] data;
  } acc_t;

  acc_t        exp_q[$];
  logic [31:0] mem    [0:8191];
  logic [31:0] shadow [0:8191];

  always #5 clk = ~clk;

  vec_calc_seq #(.AW(13), .DW(32)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .done_clr(done_clr),
    .cfg_len(cfg_len), .cfg_op(cfg_op), .src_a_base(src_a_base),
    .src_b_base(src_b_base), .dst_base(dst_base),
    .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
    .host_rd_en(host_rd_en), .host_rd_addr(host_rd_addr), .host_rd_data(host_rd_data),
    .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
    .busy(busy), .done(done), .elem_cnt(elem_cnt)
  );

  // single-port synchronous SRAM
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) mem[sram_addr] <= sram_wdata;
      else         sram_rdata <= mem[sram_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] model_f(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a ^ b;
      default: return (a > b) ? a : b;
    endcase
  endfunction

  // every cycle: host priority, read pass-through, engine accesses in model order
  always @(negedge clk) begin : mon_p
    acc_t e;
    if (mon_on) begin
      chk("rd_pass", host_rd_data, sram_rdata);
      if (host_wr_en) begin
        chk("hwr_strobe", {30'd0, sram_en, sram_we}, 32'd3);
        chk("hwr_addr", 32'(sram_addr), 32'(host_wr_addr));
        chk("hwr_data", sram_wdata, host_wr_data);
      end else if (host_rd_en) begin
        chk("hrd_strobe", {30'd0, sram_en, sram_we}, 32'd2);
        chk("hrd_addr", 32'(sram_addr), 32'(host_rd_addr));
      end else if (sram_en) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL eng_extra: unexpected access we=%b addr=%h", sram_we, sram_addr);
        end else begin
          e = exp_q.pop_front();
          chk("eng_we", {31'd0, sram_we}, {31'd0, e.we});
          chk("eng_addr", 32'(sram_addr), 32'(e.addr));
          if (e.we) chk("eng_wdata", sram_wdata, e.data);
        end
      end else begin
        chk("idle_bus", {18'd0, sram_we, sram_addr}, 32'd0);
        chk("idle_wdata", sram_wdata, 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic hwrite(input logic [12:0] a, input logic [31:0] d);
    host_wr_en = 1'b1; host_wr_addr = a; host_wr_data = d; shadow[a] = d;
    step();
    host_wr_en = 1'b0;
  endtask

  // queue the expected access stream, then pulse start (returns in cycle 1)
  task automatic launch(input int n, input logic [1:0] op, input logic [12:0] a,
                        input logic [12:0] b, input logic [12:0] d);
    logic [12:0] ai, bi, di;
    for (int i = 0; i < n; i++) begin
      ai = a + 13'(i); bi = b + 13'(i); di = d + 13'(i);
      exp_q.push_back('{1'b0, ai, 32'd0});
      exp_q.push_back('{1'b0, bi, 32'd0});
      exp_q.push_back('{1'b1, di, model_f(op, shadow[ai], shadow[bi])});
    end
    cfg_len = 13'(n); cfg_op = op; src_a_base = a; src_b_base = b; dst_base = d;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // run from cycle 1 until done && !busy, injecting host writes per mask
  task automatic wait_done(input logic [63:0] hmask, input int exp_cyc, input string nm);
    int k;
    k = 1;
    while (!(done === 1'b1 && busy === 1'b0) && k < 300) begin
      if (k < 64 && hmask[k]) begin
        host_wr_en = 1'b1; host_wr_addr = 13'h500 + 13'(k); host_wr_data = 32'hA000_0000 + 32'(k);
      end
      step();
      host_wr_en = 1'b0;
      k++;
    end
    chk(nm, 32'(k), 32'(exp_cyc));
    chk({nm, "_qempty"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; done_clr = 1'b0;
    cfg_len = 13'd0; cfg_op = 2'd0; src_a_base = 13'd0; src_b_base = 13'd0; dst_base = 13'd0;
    host_wr_en = 1'b0; host_rd_en = 1'b0; host_wr_addr = 13'd0; host_rd_addr = 13'd0;
    host_wr_data = 32'd0;
    for (int i = 0; i < 8192; i++) shadow[i] = 32'd0;
    step(); step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_cnt", 32'(elem_cnt), 32'd0);
    chk("rst_en", {31'd0, sram_en}, 32'd0);
    rst = 1'b0;
    mon_on = 1'b1;

    // operand preload through the host port
    hwrite(13'h100, 32'd1); hwrite(13'h101, 32'd2); hwrite(13'h102, 32'd3);
    hwrite(13'h103, 32'hFFFF_FFFF);
    hwrite(13'h104, 32'd4); hwrite(13'h105, 32'd5); hwrite(13'h106, 32'd6); hwrite(13'h107, 32'd7);
    hwrite(13'h200, 32'd10); hwrite(13'h201, 32'd20); hwrite(13'h202, 32'd30); hwrite(13'h203, 32'd2);
    for (int i = 4; i < 8; i++) hwrite(13'h200 + 13'(i), 32'd0);
    hwrite(13'd8191, 32'd5); hwrite(13'd0, 32'd0); hwrite(13'h400, 32'd7); hwrite(13'h401, 32'd1);
    for (int i = 0; i < 8; i++) hwrite(13'h800 + 13'(i), 32'hDEAD_BEEF);

    // add, no contention
    launch(4, 2'd0, 13'h100, 13'h200, 13'h300);
    chk("add_busy_c1", {31'd0, busy}, 32'd1);
    wait_done(64'd0, 18, "add_done_cyc");
    chk("add_cnt", 32'(elem_cnt), 32'd4);
    chk("add_r0", mem[13'h300], 32'd11);
    chk("add_r1", mem[13'h301], 32'd22);
    chk("add_r2", mem[13'h302], 32'd33);
    chk("add_r3", mem[13'h303], 32'd1);
    host_rd_en = 1'b1; host_rd_addr = 13'h301;
    step();
    host_rd_en = 1'b0;
    chk("host_rd", host_rd_data, 32'd22);
    step(); step();
    chk("done_sticky", {31'd0, done}, 32'd1);
    done_clr = 1'b1;
    step();
    done_clr = 1'b0;
    chk("done_clr", {31'd0, done}, 32'd0);

    // host writes colliding on cycles 1, 2 and 8
    launch(4, 2'd0, 13'h100, 13'h200, 13'h310);
    wait_done(64'h106, 21, "stall_done_cyc");
    chk("stall_r0", mem[13'h310], 32'd11);
    chk("stall_r3", mem[13'h313], 32'd1);
    chk("stall_h1", mem[13'h501], 32'hA000_0001);
    chk("stall_h8", mem[13'h508], 32'hA000_0008);

    // sub / max / xor with source A wrapping 8191 -> 0
    launch(2, 2'd1, 13'd8191, 13'h400, 13'h600);
    wait_done(64'd0, 10, "sub_done_cyc");
    chk("sub_r0", mem[13'h600], 32'hFFFF_FFFE);
    chk("sub_r1", mem[13'h601], 32'hFFFF_FFFF);
    launch(2, 2'd3, 13'd8191, 13'h400, 13'h610);
    wait_done(64'd0, 10, "max_done_cyc");
    chk("max_r0", mem[13'h610], 32'd7);
    chk("max_r1", mem[13'h611], 32'd1);
    launch(2, 2'd2, 13'h102, 13'h202, 13'h700);
    wait_done(64'd0, 10, "xor_done_cyc");
    chk("xor_r0", mem[13'h700], 32'd29);
    chk("xor_r1", mem[13'h701], 32'hFFFF_FFFD);

    // zero-length job
    launch(0, 2'd0, 13'h100, 13'h200, 13'h300);
    chk("n0_busy_c1", {31'd0, busy}, 32'd1);
    wait_done(64'd0, 2, "n0_done_cyc");

    // abort at cycle 10, with an ignored start while busy
    launch(8, 2'd0, 13'h100, 13'h200, 13'h800);
    for (int k = 1; k < 10; k++) begin
      if (k == 5) begin start = 1'b1; cfg_len = 13'd1; end
      step();
      start = 1'b0;
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_cnt", 32'(elem_cnt), 32'd2);
    chk("abort_r0", mem[13'h800], 32'd11);
    chk("abort_r1", mem[13'h801], 32'd22);
    for (int i = 2; i < 8; i++) chk("abort_untouched", mem[13'h800 + 13'(i)], 32'hDEAD_BEEF);
    exp_q.delete();
    step();
    done_clr = 1'b1;
    step();
    done_clr = 1'b0;
    launch(8, 2'd0, 13'h100, 13'h200, 13'h800);
    wait_done(64'd0, 34, "restart_done_cyc");
    chk("restart_cnt", 32'(elem_cnt), 32'd8);
    chk("restart_r4", mem[13'h804], 32'd4);
    chk("restart_r7", mem[13'h807], 32'd7);

    // synchronous reset during element 3
    launch(8, 2'd0, 13'h100, 13'h200, 13'h900);
    for (int k = 1; k < 14; k++) step();
    chk("pre_rst_cnt", 32'(elem_cnt), 32'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_done", {31'd0, done}, 32'd0);
    chk("mid_rst_cnt", 32'(elem_cnt), 32'd0);
    chk("mid_rst_en", {31'd0, sram_en}, 32'd0);
    exp_q.delete();
    step();
    launch(4, 2'd0, 13'h100, 13'h200, 13'hA00);
    wait_done(64'd0, 18, "post_rst_done_cyc");
    chk("post_rst_r0", mem[13'hA00], 32'd11);
    chk("post_rst_r3", mem[13'hA03], 32'd1);

    step();
    mon_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
